// File: rtl/change_dispenser.sv
// Change dispenser: plans a greedy, inventory-limited coin breakdown of a requested amount,
// then pays it out one coin per valid/ack handshake, or refuses the whole request.
module change_dispenser #(
    parameter int INIT_HI = 0,
    parameter int INIT_LO = 20,
    parameter int CNT_W   = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_money,
    input  logic        i_money_strobe,
    input  logic        i_coin_ack,
    input  logic        i_refill,
    output logic [3:0]  o_coin,
    output logic        o_coin_valid,
    output logic        o_change_ready,
    output logic        o_no_change,
    output logic        o_busy
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PLAN = 3'd1;
    localparam logic [2:0] S_DISP = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_FAIL = 3'd4;

    localparam logic [3:0]       IDX_END = 4'd15;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Slot 15 is a sentinel past the last denomination; it always holds zero.
    function automatic logic [CNT_W-1:0] init_count(input logic [3:0] i);
        longint lim;
        longint v;
        lim = (longint'(1) << CNT_W) - 1;
        v   = (i < 4'd4) ? longint'(INIT_HI) : longint'(INIT_LO);
        if (i == IDX_END) return '0;
        if (v < 0)        return '0;
        if (v > lim)      return '1;
        return CNT_W'(v);
    endfunction

    function automatic logic [31:0] denom_value(input logic [3:0] i);
        case (i)
            4'd0:    return 32'd50000;
            4'd1:    return 32'd20000;
            4'd2:    return 32'd10000;
            4'd3:    return 32'd5000;
            4'd4:    return 32'd2000;
            4'd5:    return 32'd1000;
            4'd6:    return 32'd500;
            4'd7:    return 32'd200;
            4'd8:    return 32'd100;
            4'd9:    return 32'd50;
            4'd10:   return 32'd25;
            4'd11:   return 32'd10;
            4'd12:   return 32'd5;
            4'd13:   return 32'd2;
            4'd14:   return 32'd1;
            default: return 32'd0;
        endcase
    endfunction

    logic [2:0]       state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [31:0]      rem_q, rem_d;
    logic [CNT_W-1:0] inv_q  [16];
    logic [CNT_W-1:0] inv_d  [16];
    logic [CNT_W-1:0] plan_q [16];
    logic [CNT_W-1:0] plan_d [16];

    logic [31:0]      cur_val;
    logic [CNT_W-1:0] cur_plan;
    logic [CNT_W-1:0] cur_inv;

    assign cur_val  = denom_value(idx_q);
    assign cur_plan = plan_q[idx_q];
    assign cur_inv  = inv_q[idx_q];

    assign o_coin_valid   = (state_q == S_DISP) && (idx_q != IDX_END) && (cur_plan != '0);
    assign o_coin         = o_coin_valid ? (idx_q + 4'd1) : 4'd0;
    assign o_change_ready = (state_q == S_DONE);
    assign o_no_change    = (state_q == S_FAIL);
    assign o_busy         = (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        inv_d   = inv_q;
        plan_d  = plan_q;
        case (state_q)
            S_IDLE: begin
                if (i_money_strobe) begin
                    if (i_money == 32'd0) begin
                        state_d = S_DONE;
                    end else begin
                        rem_d   = i_money;
                        idx_d   = 4'd0;
                        state_d = S_PLAN;
                        for (int i = 0; i < 16; i++) plan_d[i] = '0;
                    end
                end else if (i_refill) begin
                    for (int i = 0; i < 16; i++) inv_d[i] = init_count(4'(i));
                end
            end
            S_PLAN: begin
                if (idx_q == IDX_END) begin
                    if (rem_q == 32'd0) begin
                        state_d = S_DISP;
                        idx_d   = 4'd0;
                    end else begin
                        state_d = S_FAIL;
                    end
                end else if ((rem_q >= cur_val) && (cur_plan < cur_inv)) begin
                    plan_d[idx_q] = cur_plan + CNT_ONE;
                    rem_d         = rem_q - cur_val;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            S_DISP: begin
                if (idx_q == IDX_END) begin
                    state_d = S_DONE;
                end else if (cur_plan == '0) begin
                    idx_d = idx_q + 4'd1;
                end else if (i_coin_ack) begin
                    plan_d[idx_q] = cur_plan - CNT_ONE;
                    if (cur_inv != '0) inv_d[idx_q] = cur_inv - CNT_ONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst_n) begin
        if (i_rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            rem_q   <= 32'd0;
            for (int i = 0; i < 16; i++) begin
                inv_q[i]  <= init_count(4'(i));
                plan_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            inv_q   <= inv_d;
            plan_q  <= plan_d;
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: fixed vectors, hand-written corner sequences and random
// requests checked against a greedy-breakdown inventory model.
module tb_change_dispenser;

    localparam int INIT_HI = 0;
    localparam int INIT_LO = 20;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic [31:0] i_money = '0;
    logic        i_money_strobe = 1'b0;
    logic        i_coin_ack = 1'b0;
    logic        i_refill = 1'b0;
    logic [3:0]  o_coin;
    logic        o_coin_valid;
    logic        o_change_ready;
    logic        o_no_change;
    logic        o_busy;

    change_dispenser #(.INIT_HI(INIT_HI), .INIT_LO(INIT_LO), .CNT_W(8)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_money        (i_money),
        .i_money_strobe (i_money_strobe),
        .i_coin_ack     (i_coin_ack),
        .i_refill       (i_refill),
        .o_coin         (o_coin),
        .o_coin_valid   (o_coin_valid),
        .o_change_ready (o_change_ready),
        .o_no_change    (o_no_change),
        .o_busy         (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int nerr = 0;
    int nchk = 0;

    localparam int VAL [15] = '{50000, 20000, 10000, 5000, 2000, 1000, 500, 200, 100, 50,
                                25, 10, 5, 2, 1};
    int inv_m [15];
    int exp_q [$];

    typedef struct {
        longint amt;
        int     delay;
        bit     exp_ok;
        int     exp_n;
        int     exp_first;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reload();
        for (int i = 0; i < 15; i++) inv_m[i] = (i < 4) ? INIT_HI : INIT_LO;
    endtask

    // Greedy largest-first under stock limits; the stock is only consumed on success.
    task automatic model_plan(input longint amt, output bit ok, output int n);
        longint rem;
        longint q;
        int take [15];
        rem = amt;
        n = 0;
        exp_q.delete();
        for (int i = 0; i < 15; i++) begin
            q = rem / VAL[i];
            if (q > inv_m[i]) q = inv_m[i];
            take[i] = int'(q);
            rem -= q * VAL[i];
        end
        ok = (rem == 0);
        if (ok) begin
            for (int i = 0; i < 15; i++) begin
                for (int k = 0; k < take[i]; k++) exp_q.push_back(i + 1);
                inv_m[i] -= take[i];
                n += take[i];
            end
        end
    endtask

    task automatic run_req(input longint amt, input int first_delay, input bit with_refill,
                           output bit ok_seen, output int ncoins, output int first_code);
        bit exp_ok;
        int exp_n;
        bit done;
        int cyc;
        int delay;
        int wcnt;
        model_plan(amt, exp_ok, exp_n);
        ok_seen = 1'b0;
        ncoins = 0;
        first_code = 0;
        done = 1'b0;
        cyc = 0;
        delay = first_delay;
        wcnt = 0;
        @(negedge i_clk);
        i_money = amt[31:0];
        i_money_strobe = 1'b1;
        i_refill = with_refill;
        @(negedge i_clk);
        i_money_strobe = 1'b0;
        while (!done && cyc < 4000) begin
            i_coin_ack = 1'b0;
            i_refill = 1'b0;
            if (o_change_ready || o_no_change) begin
                done = 1'b1;
                ok_seen = o_change_ready;
                check("pulse exclusive", longint'(o_change_ready & o_no_change), 0);
            end else if (o_coin_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected coin", longint'(o_coin), 0);
                    i_coin_ack = 1'b1;
                    ncoins++;
                end else if (wcnt < delay) begin
                    check("coin held", longint'(o_coin), exp_q[0]);
                    wcnt++;
                end else begin
                    check("coin code", longint'(o_coin), exp_q[0]);
                    if (ncoins == 0) first_code = int'(o_coin);
                    void'(exp_q.pop_front());
                    i_coin_ack = 1'b1;
                    ncoins++;
                    wcnt = 0;
                    delay = $urandom_range(0, 2);
                end
            end else begin
                i_coin_ack = ($urandom_range(0, 3) == 0);
            end
            if (!done && o_busy) i_refill = ($urandom_range(0, 3) == 0);
            if (!done) begin
                @(negedge i_clk);
                cyc++;
            end
        end
        if (!done) check("request timeout", 0, 1);
        check("outcome", longint'(ok_seen), longint'(exp_ok));
        check("coin count", ncoins, exp_n);
        @(negedge i_clk);
        i_coin_ack = 1'b0;
        i_refill = 1'b0;
        check("pulse one cycle", longint'(o_change_ready | o_no_change), 0);
        check("idle after", longint'(o_busy), 0);
    endtask

    task automatic wait_valid(output bit got);
        got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (o_coin_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge i_clk);
        end
    endtask

    initial begin
        bit ok_seen;
        bit got;
        int ncoins;
        int first_code;
        int busy_cnt;
        int ready_cnt;
        int nochg_cnt;
        longint amt;

        tbl[0] = '{amt: 130,   delay: 0, exp_ok: 1'b1, exp_n: 3, exp_first: 9};
        tbl[1] = '{amt: 130,   delay: 5, exp_ok: 1'b1, exp_n: 3, exp_first: 9};
        tbl[2] = '{amt: 5000,  delay: 0, exp_ok: 1'b1, exp_n: 3, exp_first: 5};
        tbl[3] = '{amt: 80000, delay: 0, exp_ok: 1'b0, exp_n: 0, exp_first: 0};
        tbl[4] = '{amt: 0,     delay: 0, exp_ok: 1'b1, exp_n: 0, exp_first: 0};

        model_reload();
        repeat (3) @(negedge i_clk);
        check("reset valid", longint'(o_coin_valid), 0);
        check("reset coin", longint'(o_coin), 0);
        check("reset busy", longint'(o_busy), 0);
        check("reset ready", longint'(o_change_ready | o_no_change), 0);
        i_rst_n = 1'b0;
        @(negedge i_clk);

        for (int t = 0; t < 5; t++) begin
            run_req(tbl[t].amt, tbl[t].delay, 1'b0, ok_seen, ncoins, first_code);
            check($sformatf("vec%0d ok", t), longint'(ok_seen), longint'(tbl[t].exp_ok));
            check($sformatf("vec%0d ncoins", t), ncoins, tbl[t].exp_n);
            check($sformatf("vec%0d first", t), first_code, tbl[t].exp_first);
        end

        // Zero request: one busy cycle carrying the ready pulse.
        @(negedge i_clk);
        i_money = 32'd0;
        i_money_strobe = 1'b1;
        @(negedge i_clk);
        i_money_strobe = 1'b0;
        busy_cnt = 0;
        ready_cnt = 0;
        nochg_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (o_busy) busy_cnt++;
            if (o_change_ready && o_busy) ready_cnt++;
            if (o_no_change) nochg_cnt++;
            @(negedge i_clk);
        end
        check("zero busy cycles", busy_cnt, 1);
        check("zero ready pulses", ready_cnt, 1);
        check("zero no_change", nochg_cnt, 0);

        // Reset in the middle of dispensing 130, after the first coin was taken.
        @(negedge i_clk);
        i_money = 32'd130;
        i_money_strobe = 1'b1;
        @(negedge i_clk);
        i_money_strobe = 1'b0;
        wait_valid(got);
        check("mid first valid", longint'(got), 1);
        check("mid first coin", longint'(o_coin), 9);
        i_coin_ack = 1'b1;
        @(negedge i_clk);
        i_coin_ack = 1'b0;
        wait_valid(got);
        check("mid second valid", longint'(got), 1);
        check("mid second coin", longint'(o_coin), 11);
        i_rst_n = 1'b1;
        #1;
        check("async rst valid", longint'(o_coin_valid), 0);
        check("async rst coin", longint'(o_coin), 0);
        check("async rst busy", longint'(o_busy), 0);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        model_reload();
        // Full stock is only payable if every inventory was restored.
        run_req(77860, 0, 1'b0, ok_seen, ncoins, first_code);
        check("full stock ok", longint'(ok_seen), 1);
        check("full stock coins", ncoins, 220);

        model_reload();
        @(negedge i_clk);
        i_refill = 1'b1;
        @(negedge i_clk);
        i_refill = 1'b0;

        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 7) == 0) begin
                @(negedge i_clk);
                i_refill = 1'b1;
                @(negedge i_clk);
                i_refill = 1'b0;
                model_reload();
            end
            case ($urandom_range(0, 3))
                0:       amt = $urandom_range(0, 500);
                1:       amt = $urandom_range(0, 5000);
                2:       amt = $urandom_range(0, 30000);
                default: amt = longint'($urandom_range(1, 100)) * 5;
            endcase
            run_req(amt, $urandom_range(0, 3), ($urandom_range(0, 5) == 0),
                    ok_seen, ncoins, first_code);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
